// File: rtl/vga_trig_timing.sv
// Raster timing generator with optional frame alignment to an external trigger.
// Free-runs by default; in trigger mode each frame start waits for a trigger edge or a timeout.
module vga_trig_timing #(
    parameter int unsigned H_TOTAL      = 800,
    parameter int unsigned V_TOTAL      = 525,
    parameter int unsigned H_BLANK      = 160,
    parameter int unsigned V_BLANK      = 45,
    parameter int unsigned TRIG_TIMEOUT = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        trig_i,
    input  logic        trig_en_i,
    output logic [15:0] h_cont_o,
    output logic [15:0] v_cont_o,
    output logic        line_start_o,
    output logic        frame_start_o,
    output logic        active_o,
    output logic [15:0] frame_cnt_o,
    output logic        locked_o
);

    localparam logic [15:0] HMax   = 16'(H_TOTAL - 1);
    localparam logic [15:0] VMax   = 16'(V_TOTAL - 1);
    localparam logic [15:0] HBlank = 16'(H_BLANK);
    localparam logic [15:0] VBlank = 16'(V_BLANK);
    localparam logic [31:0] TmoMax = 32'(TRIG_TIMEOUT - 1);

    localparam logic [0:0] StRun  = 1'b0;
    localparam logic [0:0] StWait = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [15:0] h_q, h_d;
    logic [15:0] v_q, v_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] tmo_q, tmo_d;
    logic        pending_q, pending_d;
    logic        locked_q, locked_d;
    logic        sync1_q, sync2_q, sync3_q;

    logic run;
    logic h_last;
    logic v_last;
    logic trig_edge;

    assign run       = (state_q == StRun);
    assign h_last    = (h_q == HMax);
    assign v_last    = (v_q == VMax);
    // sync3 acts as the edge-detect register behind the two-stage synchronizer
    assign trig_edge = sync2_q & ~sync3_q;

    assign frame_start_o = run && (h_q == 16'd0) && (v_q == 16'd0);
    assign line_start_o  = run && (h_q == 16'd0);
    assign active_o      = run && (h_q >= HBlank) && (v_q >= VBlank);
    assign h_cont_o      = h_q;
    assign v_cont_o      = v_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign locked_o      = locked_q;

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        v_d         = v_q;
        pending_d   = pending_q;
        locked_d    = locked_q;
        tmo_d       = tmo_q;
        frame_cnt_d = frame_cnt_q + {15'd0, frame_start_o};

        case (state_q)
            StRun: begin
                if (trig_edge) begin
                    pending_d = 1'b1;
                end
                if (h_last) begin
                    h_d = 16'd0;
                    v_d = v_last ? 16'd0 : v_q + 16'd1;
                end else begin
                    h_d = h_q + 16'd1;
                end
                // A trigger landing on the frame-end cycle itself still counts as pending
                if (h_last && v_last) begin
                    if (!trig_en_i) begin
                        locked_d = 1'b0;
                    end else if (pending_q || trig_edge) begin
                        pending_d = 1'b0;
                        locked_d  = 1'b1;
                    end else begin
                        state_d   = StWait;
                        pending_d = 1'b0;
                        tmo_d     = 32'd0;
                    end
                end
            end
            default: begin
                h_d       = 16'd0;
                v_d       = 16'd0;
                pending_d = 1'b0;
                tmo_d     = tmo_q + 32'd1;
                if (trig_edge) begin
                    state_d  = StRun;
                    locked_d = 1'b1;
                end else if (!trig_en_i || (tmo_q == TmoMax)) begin
                    state_d  = StRun;
                    locked_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StRun;
            h_q         <= 16'd0;
            v_q         <= 16'd0;
            frame_cnt_q <= 16'd0;
            tmo_q       <= 32'd0;
            pending_q   <= 1'b0;
            locked_q    <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            v_q         <= v_d;
            frame_cnt_q <= frame_cnt_d;
            tmo_q       <= tmo_d;
            pending_q   <= pending_d;
            locked_q    <= locked_d;
            sync1_q     <= trig_i;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
        end
    end

endmodule

// File: tb/tb_vga_trig_timing.sv
// Directed bench for vga_trig_timing using a reduced 20x10 raster (200 cycles per frame).
module tb_vga_trig_timing;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trig;
    logic        trig_en;
    logic [15:0] h;
    logic [15:0] v;
    logic        ls;
    logic        fs;
    logic        act;
    logic [15:0] cnt;
    logic        locked;

    int n_checks = 0;
    int n_fail   = 0;

    vga_trig_timing #(
        .H_TOTAL     (20),
        .V_TOTAL     (10),
        .H_BLANK     (4),
        .V_BLANK     (2),
        .TRIG_TIMEOUT(50)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .trig_i       (trig),
        .trig_en_i    (trig_en),
        .h_cont_o     (h),
        .v_cont_o     (v),
        .line_start_o (ls),
        .frame_start_o(fs),
        .active_o     (act),
        .frame_cnt_o  (cnt),
        .locked_o     (locked)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int hv_err = 0, act_err = 0, fs_err = 0, lk_err = 0;
        int ls_cnt = 0, act_cnt = 0, first_act = -1, werr = 0;
        int eh, ev;

        rst_n   = 1'b0;
        trig    = 1'b0;
        trig_en = 1'b0;
        #12;
        chk("rst_h", h, 0);
        chk("rst_v", v, 0);
        chk("rst_fs", fs, 1);
        chk("rst_ls", ls, 1);
        chk("rst_cnt", cnt, 0);
        chk("rst_locked", locked, 0);
        chk("rst_active", act, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Free-run: three frames, position 0 is the first post-reset cycle
        for (int i = 0; i < 600; i++) begin
            eh = i % 20;
            ev = (i / 20) % 10;
            if (h !== 16'(eh) || v !== 16'(ev)) hv_err++;
            if (act !== ((eh >= 4) && (ev >= 2))) act_err++;
            if (fs !== ((i % 200) == 0)) fs_err++;
            if (locked !== 1'b0) lk_err++;
            if (ls === 1'b1) ls_cnt++;
            if (act === 1'b1) begin
                act_cnt++;
                if (first_act < 0) first_act = i;
            end
            if (i == 1) chk("cnt_first_edge", cnt, 1);
            step(1);
        end
        chk("free_hv_seq", hv_err, 0);
        chk("free_active_seq", act_err, 0);
        chk("free_fs_period", fs_err, 0);
        chk("free_locked", lk_err, 0);
        chk("free_line_starts", ls_cnt, 30);
        chk("free_active_cycles", act_cnt, 3 * 16 * 8);
        chk("free_first_active", first_act, 2 * 20 + 4);
        chk("free_cnt3", cnt, 3);
        chk("free_fs_wrap", fs, 1);

        // Trigger mode with no trigger: hold in WAIT
        trig_en = 1'b1;
        step(200);
        chk("wait_h", h, 0);
        chk("wait_v", v, 0);
        chk("wait_fs", fs, 0);
        chk("wait_ls", ls, 0);
        chk("wait_cnt", cnt, 4);
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (fs !== 1'b0 || ls !== 1'b0 || act !== 1'b0 || h !== 16'd0 || v !== 16'd0) werr++;
        end
        chk("wait_hold", werr, 0);
        trig = 1'b1;
        step(1);
        chk("lock_lat1", fs, 0);
        step(1);
        chk("lock_lat2", fs, 0);
        step(1);
        chk("lock_fs", fs, 1);
        chk("lock_locked", locked, 1);
        chk("lock_h", h, 0);

        // Timeout after 50 WAIT cycles
        trig = 1'b0;
        step(200);
        chk("tmo_enter", fs, 0);
        werr = 0;
        for (int i = 0; i < 49; i++) begin
            step(1);
            if (fs !== 1'b0) werr++;
        end
        chk("tmo_early", werr, 0);
        step(1);
        chk("tmo_fs", fs, 1);
        chk("tmo_locked", locked, 0);

        // Pending trigger raised mid-frame
        step(40);
        trig = 1'b1;
        step(100);
        trig = 1'b0;
        step(59);
        chk("pend_end_h", h, 19);
        chk("pend_end_v", v, 9);
        chk("pend_pre_locked", locked, 0);
        step(1);
        chk("pend_fs", fs, 1);
        chk("pend_locked", locked, 1);

        // Trigger edge landing on the frame-end cycle
        trig_en = 1'b0;
        step(200);
        chk("free_unlock", locked, 0);
        chk("free_unlock_fs", fs, 1);
        trig_en = 1'b1;
        step(197);
        trig = 1'b1;
        step(2);
        chk("coin_end_h", h, 19);
        chk("coin_end_v", v, 9);
        step(1);
        chk("coin_fs", fs, 1);
        chk("coin_locked", locked, 1);

        // Trigger mode dropped while in WAIT
        trig = 1'b0;
        step(200);
        chk("en_wait", fs, 0);
        step(5);
        trig_en = 1'b0;
        step(1);
        chk("en_exit_fs", fs, 1);
        chk("en_exit_locked", locked, 0);

        // Asynchronous reset with a trigger pending
        trig_en = 1'b1;
        step(40);
        trig = 1'b1;
        step(10);
        trig = 1'b0;
        step(57);
        chk("pre_rst_h", h, 7);
        chk("pre_rst_v", v, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_h", h, 0);
        chk("arst_v", v, 0);
        chk("arst_cnt", cnt, 0);
        chk("arst_fs", fs, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step(200);
        chk("arst_no_pend", fs, 0);
        chk("arst_no_pend_h", h, 0);
        chk("arst_cnt1", cnt, 1);
        chk("arst_locked", locked, 0);

        // Frame counter wrap from 0xFFFF
        trig_en = 1'b0;
        step(1);
        chk("wrap_run_fs", fs, 1);
        step(198);
        force dut.frame_cnt_q = 16'hFFFF;
        step(1);
        release dut.frame_cnt_q;
        chk("wrap_preload", cnt, 16'hFFFF);
        step(1);
        chk("wrap_fs", fs, 1);
        chk("wrap_hold", cnt, 16'hFFFF);
        step(1);
        chk("wrap_zero", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
